// File: rtl/qu_common_pkg.sv
// Shared front-end types: program counters, fetch queue entries and fetch FSM states.
package qu_common;

  typedef logic [31:0] pc_t;

  localparam int unsigned INSTR_WIDTH_DEFAULT    = 32;
  localparam pc_t         RESET_PC_DEFAULT       = 32'h0000_0000;
  localparam int unsigned FETCH_IQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    pc_t                            pc;
    logic [INSTR_WIDTH_DEFAULT-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

  function automatic pc_t pc_word_align(input pc_t pc);
    return pc & ~pc_t'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; head is read combinationally from storage.
module fetch_queue
  import qu_common::*;
#(
  parameter int unsigned DEPTH = FETCH_IQ_DEPTH_DEFAULT,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  fetch_entry_t i_push_dat,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [CW-1:0] o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch.sv
// Sequential instruction fetch feeding decode through a small queue; redirect flushes and restarts.
// QU_FETCH_MISALIGN_CHECK_EN adds a FAULT state and the fetch_fault port for misaligned redirects.
module fetch
  import qu_common::*;
#(
  parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
  parameter int unsigned IQ_DEPTH    = FETCH_IQ_DEPTH_DEFAULT,
  parameter pc_t         RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_en,
  output pc_t                    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect,
  input  pc_t                    redirect_pc,
  output logic                   instr_valid,
  input  logic                   decode_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output pc_t                    pc_out
`ifdef QU_FETCH_MISALIGN_CHECK_EN
  ,
  output logic                   fetch_fault
`endif
);

  localparam int unsigned CW = $clog2(IQ_DEPTH) + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  pc_t           r_fetch_pc;
  pc_t           r_resp_pc;
  logic          r_inflight;
  logic          r_kill;
  pc_t           w_redirect_pc;
  logic          w_misaligned;
  logic          w_issue;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_push_dat;
  fetch_entry_t  w_head;

`ifdef QU_FETCH_MISALIGN_CHECK_EN
  assign w_redirect_pc = redirect_pc;
  assign w_misaligned  = |redirect_pc[1:0];
  assign fetch_fault   = (r_state == FETCH_FAULT);
`else
  assign w_redirect_pc = pc_word_align(redirect_pc);
  assign w_misaligned  = 1'b0;
`endif

  // Queued entries plus the word in flight may never exceed the queue, so a push always fits.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_valid     = 1'b0;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    if (redirect) w_state_nxt = w_misaligned ? FETCH_FAULT : FETCH_RUN;
    w_issue = !rst && !redirect && (r_state == FETCH_RUN) &&
              ((w_count + CW'(r_inflight)) < CW'(IQ_DEPTH));
    w_valid = (w_count != '0) && !redirect;
    w_pop   = w_valid && decode_ready;
    w_push  = r_inflight && !r_kill && !redirect && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH_RUN;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_issue) r_resp_pc <= r_fetch_pc;
      // A word arriving during the redirect cycle is blocked from the push directly;
      // kill covers any request that would still be outstanding across the flush edge.
      if (redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_kill     <= w_issue;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (r_inflight) r_kill <= 1'b0;
      end
    end
  end

  assign w_push_dat = '{pc: r_resp_pc, instr: imem_rdata};

  fetch_queue #(
    .DEPTH(IQ_DEPTH)
  ) u_queue (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (redirect),
    .o_count    (w_count),
    .o_head     (w_head)
  );

  assign imem_en     = w_issue;
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = w_valid;
  assign instr_out   = w_head.instr;
  assign pc_out      = w_head.pc;

endmodule
